// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with per-register pending bits, writeback
// bypass to the read ports and an optional hardwired zero register.
module regfile_scoreboard #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_ready,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     flush,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [ADDR_W:0]   busy_q, busy_d;
    logic              wb_eff, iss_eff;
    logic [ADDR_W-1:0] ra;
    logic              hit;

    // Writes and issues aimed at the hardwired zero register are dropped here.
    always_comb begin
        wb_eff  = wb_en;
        iss_eff = iss_en;
        if (ZERO_REG != 0 && wb_addr == '0) begin
            wb_eff = 1'b0;
        end
        if (ZERO_REG != 0 && iss_addr == '0) begin
            iss_eff = 1'b0;
        end
    end

    // Issue is applied after writeback so a same-register issue wins.
    always_comb begin
        pend_d = pend_q;
        if (wb_eff) begin
            pend_d[wb_addr] = 1'b0;
        end
        if (iss_eff) begin
            pend_d[iss_addr] = 1'b1;
        end
        if (flush) begin
            pend_d = '0;
        end
        busy_d = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            busy_d = busy_d + {{ADDR_W{1'b0}}, pend_d[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            busy_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            pend_q <= pend_d;
            busy_q <= busy_d;
            if (wb_eff) begin
                regs_q[wb_addr] <= wb_data;
            end
        end
    end

    assign busy_cnt = busy_q;

    always_comb begin
        rd_data  = '0;
        rd_ready = '0;
        ra       = '0;
        hit      = 1'b0;
        for (int i = 0; i < int'(NUM_RD); i++) begin
            ra  = rd_addr[i*ADDR_W +: ADDR_W];
            hit = (BYPASS != 0) && wb_en && (wb_addr == ra);
            if (ZERO_REG != 0 && ra == '0) begin
                rd_data[i*DATA_W +: DATA_W] = '0;
                rd_ready[i]                 = 1'b1;
            end else begin
                rd_data[i*DATA_W +: DATA_W] = hit ? wb_data : regs_q[ra];
                rd_ready[i]                 = !pend_q[ra] || hit;
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus random
// traffic compared against an array-based reference model.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_ready;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        flush;
    logic [5:0]  busy_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_reg  [32];
    bit          m_pend [32];

    regfile_scoreboard dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_ready (rd_ready),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .busy_cnt (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void m_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
        end
    endfunction

    // Register 0 is constant zero and never pending; everything else follows
    // write-then-issue-then-flush ordering at the edge.
    function automatic void m_step();
        if (wb_en && wb_addr != 0) begin
            m_reg[wb_addr]  = wb_data;
            m_pend[wb_addr] = 1'b0;
        end
        if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1'b1;
        if (flush) for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    endfunction

    function automatic logic [31:0] m_data(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wb_en && wb_addr == a) return wb_data;
        return m_reg[a];
    endfunction

    function automatic logic m_ready(input logic [4:0] a);
        if (a == 0) return 1'b1;
        return !m_pend[a] || (wb_en && wb_addr == a);
    endfunction

    function automatic logic [5:0] m_busy();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
        return 6'(c);
    endfunction

    task automatic idle();
        wb_en  = 1'b0;
        iss_en = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) m_step();
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 32; i++) begin
            rd_addr = {5'(31 - i), 5'(i)};
            #1;
            n_checks++;
            if (rd_data !== 64'h0 || rd_ready !== 2'b11 || busy_cnt !== 6'd0) begin
                n_fail++;
                $display("FAIL reset addr %0d: data=%h ready=%b busy=%0d, want 0/11/0",
                         i, rd_data, rd_ready, busy_cnt);
            end
        end
    endtask

    task automatic test_write_read();
        for (int a = 1; a < 32; a++) begin
            wb_en   = 1'b1;
            wb_addr = 5'(a);
            wb_data = 32'(a);
            tick();
        end
        idle();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 32; i++) begin
                rd_addr = {5'(31 - i), 5'(i)};
                #1;
                n_checks++;
                if (rd_data[31:0] !== 32'(i) || rd_data[63:32] !== 32'(31 - i)) begin
                    n_fail++;
                    $display("FAIL write_read pass %0d i=%0d: got %h/%h want %h/%h", pass, i,
                             rd_data[31:0], rd_data[63:32], 32'(i), 32'(31 - i));
                end
            end
            // wb_en low: address and data must be ignored
            wb_addr = 5'd5;
            wb_data = 32'hBEEEBEEE;
            tick();
        end
    endtask

    task automatic test_zero_reg();
        wb_en    = 1'b1;
        wb_addr  = 5'd0;
        wb_data  = 32'hDEADBEEF;
        iss_en   = 1'b1;
        iss_addr = 5'd0;
        rd_addr  = 10'd0;
        #1;
        n_checks++;
        if (rd_data !== 64'h0 || rd_ready !== 2'b11) begin
            n_fail++;
            $display("FAIL zero_reg same-cycle: data=%h ready=%b want 0/11", rd_data, rd_ready);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (rd_data !== 64'h0 || rd_ready !== 2'b11 || busy_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL zero_reg after: data=%h ready=%b busy=%0d want 0/11/0",
                     rd_data, rd_ready, busy_cnt);
        end
    endtask

    task automatic test_bypass();
        iss_en   = 1'b1;
        iss_addr = 5'd5;
        tick();
        idle();
        rd_addr = {5'd5, 5'd5};
        #1;
        n_checks++;
        if (rd_ready !== 2'b00 || busy_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL bypass pending: ready=%b busy=%0d want 00/1", rd_ready, busy_cnt);
        end
        wb_en   = 1'b1;
        wb_addr = 5'd5;
        wb_data = 32'h1234;
        #1;
        n_checks++;
        if (rd_data !== {32'h1234, 32'h1234} || rd_ready !== 2'b11) begin
            n_fail++;
            $display("FAIL bypass forward: data=%h ready=%b want 1234x2/11", rd_data, rd_ready);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (rd_data[31:0] !== 32'h1234 || rd_ready !== 2'b11 || busy_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL bypass settle: data=%h ready=%b busy=%0d want 1234/11/0",
                     rd_data[31:0], rd_ready, busy_cnt);
        end
    endtask

    task automatic test_issue_wb_same();
        iss_en   = 1'b1;
        iss_addr = 5'd7;
        wb_en    = 1'b1;
        wb_addr  = 5'd7;
        wb_data  = 32'd55;
        tick();
        idle();
        rd_addr = {5'd7, 5'd7};
        #1;
        n_checks++;
        if (rd_data[31:0] !== 32'd55 || rd_ready !== 2'b00 || busy_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL issue_wb_same: data=%0d ready=%b busy=%0d want 55/00/1",
                     rd_data[31:0], rd_ready, busy_cnt);
        end
        iss_en   = 1'b1;
        iss_addr = 5'd7;
        tick();
        idle();
        #1;
        n_checks++;
        if (busy_cnt !== 6'd1 || rd_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL reissue: busy=%0d ready=%b want 1/00", busy_cnt, rd_ready);
        end
    endtask

    task automatic test_flush_reset();
        for (int r = 2; r <= 4; r++) begin
            iss_en   = 1'b1;
            iss_addr = 5'(r);
            tick();
        end
        idle();
        #1;
        n_checks++;
        if (busy_cnt !== 6'd4) begin   // r7 still pending from the previous scenario
            n_fail++;
            $display("FAIL pre-flush busy: got %0d want 4", busy_cnt);
        end
        flush    = 1'b1;
        iss_en   = 1'b1;
        iss_addr = 5'd9;
        wb_en    = 1'b1;
        wb_addr  = 5'd10;
        wb_data  = 32'hA5A5;
        tick();
        idle();
        rd_addr = {5'd10, 5'd9};
        #1;
        n_checks++;
        if (busy_cnt !== 6'd0 || rd_ready !== 2'b11 || rd_data[63:32] !== 32'hA5A5) begin
            n_fail++;
            $display("FAIL flush: busy=%0d ready=%b r10=%h want 0/11/a5a5",
                     busy_cnt, rd_ready, rd_data[63:32]);
        end
        iss_en   = 1'b1;
        iss_addr = 5'd6;
        tick();
        idle();
        @(negedge clk);
        rst_n = 1'b0;
        m_reset();
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [4:0] a0, a1;
        for (int n = 0; n < 400; n++) begin
            wb_en    = 1'($urandom_range(0, 1));
            wb_addr  = 5'($urandom);
            wb_data  = $urandom;
            iss_en   = 1'($urandom_range(0, 1));
            iss_addr = 5'($urandom);
            flush    = ($urandom_range(0, 15) == 0);
            a0       = ($urandom_range(0, 3) == 0) ? wb_addr : 5'($urandom);
            a1       = ($urandom_range(0, 3) == 0) ? iss_addr : 5'($urandom);
            rd_addr  = {a1, a0};
            #1;
            n_checks++;
            if (rd_data[31:0] !== m_data(a0) || rd_data[63:32] !== m_data(a1) ||
                rd_ready !== {m_ready(a1), m_ready(a0)} || busy_cnt !== m_busy()) begin
                n_fail++;
                $display("FAIL random %0d a=%0d/%0d: data=%h/%h ready=%b busy=%0d want %h/%h %b %0d",
                         n, a0, a1, rd_data[31:0], rd_data[63:32], rd_ready, busy_cnt,
                         m_data(a0), m_data(a1), {m_ready(a1), m_ready(a0)}, m_busy());
            end
            tick();
        end
        idle();
    endtask

    initial begin
        rst_n    = 1'b0;
        rd_addr  = '0;
        wb_addr  = '0;
        wb_data  = '0;
        iss_addr = '0;
        idle();
        m_reset();
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_write_read();
        test_zero_reg();
        test_bypass();
        test_issue_wb_same();
        test_flush_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
